// File: rtl/npc_pc_reg_pkg.sv
// Shared constants for the NPC program-counter state register.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents:
//   XLEN           - PC width in bits
//   RESET_PC       - reset vector loaded while reset is asserted
//   NPC_INST_ALIGN - required value of pc[1:0] for a correctly aligned fetch
package npc_pc_reg_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    // Instructions are 4-byte aligned, so a legal PC has zero low bits.
    localparam logic [1:0] NPC_INST_ALIGN = 2'b00;

endpackage : npc_pc_reg_pkg

// File: rtl/npc_pc_align_chk.sv
// Registered misalignment flag for the PC most recently loaded into npc_pc_reg.
// Latency: 1 cycle, same edge as the PC register itself.
// Backpressure: none; loads every clock while reset is deasserted.
//
// Ports:
//   clk         in   1     system clock
//   rst         in   1     asynchronous, active-low reset
//   pc_src      in   XLEN  next PC being loaded this edge
//   pc_misalign out  1     set when the loaded PC has non-zero low bits
//
// Only built when PC_MISALIGN_CHK_EN is defined.
`ifdef PC_MISALIGN_CHK_EN
module npc_pc_align_chk #(
    parameter int unsigned XLEN = npc_pc_reg_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_src,
    output logic            pc_misalign
);

    import npc_pc_reg_pkg::*;

    logic misalign_nxt;

    // Any low bit differing from the alignment pattern marks the PC misaligned.
    assign misalign_nxt = (pc_src[1:0] != NPC_INST_ALIGN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_misalign <= 1'b0;
        end else begin
            pc_misalign <= misalign_nxt;
        end
    end

`ifndef SYNTHESIS
    // Warning for the simulation log only; no hardware is implied.
    always_ff @(posedge clk) begin
        if (rst && misalign_nxt) begin
            $display("%0t npc_pc_align_chk: warning, misaligned pc loaded: %h", $time, pc_src);
        end
    end
`endif

endmodule : npc_pc_align_chk
`endif

// File: rtl/npc_pc_reg.sv
// Program-counter state register of the single-cycle NPC fetch path; owns the reset vector.
// Latency: 1 cycle from pc_src to pc_out; reset forces RESET_PC asynchronously.
// Backpressure: none; no enable or stall, the IFU-selected next PC loads every clock.
//
// Ports:
//   clk         in   1     system clock; all state updates on posedge
//   rst         in   1     asynchronous, active-low reset
//   pc_src      in   XLEN  next PC (jal target, branch target or pc+4) from the IFU
//   pc_out      out  XLEN  current PC, straight from the register
//   pc_misalign out  1     registered misalignment flag (PC_MISALIGN_CHK_EN builds only)
//
// Build option: define PC_MISALIGN_CHK_EN to add the pc_misalign output.
// pc_out behaves identically in both builds.
module npc_pc_reg #(
    parameter int unsigned          XLEN     = npc_pc_reg_pkg::XLEN,
    parameter logic [XLEN-1:0]      RESET_PC = npc_pc_reg_pkg::RESET_PC[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_src,
`ifdef PC_MISALIGN_CHK_EN
    output logic            pc_misalign,
`endif
    output logic [XLEN-1:0] pc_out
);

    import npc_pc_reg_pkg::*;

    // The value is stored verbatim: misaligned PCs and wrap-around to zero pass
    // through untouched, the IFU deals with them downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out <= RESET_PC;
        end else begin
            pc_out <= pc_src;
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    npc_pc_align_chk #(
        .XLEN (XLEN)
    ) u_align_chk (
        .clk         (clk),
        .rst         (rst),
        .pc_src      (pc_src),
        .pc_misalign (pc_misalign)
    );
`endif

endmodule : npc_pc_reg

// File: tb/tb_npc_pc_reg.sv
// Directed self-checking bench for npc_pc_reg.
// Latency checked: 1 cycle pc_src -> pc_out, asynchronous reset.
// Backpressure: none in the design; stimulus drives a new PC every cycle.
module tb_npc_pc_reg;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] RST_VEC = 64'h0000_0000_8000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XLEN-1:0] pc_src = '0;
    logic [XLEN-1:0] pc_out;
`ifdef PC_MISALIGN_CHK_EN
    logic            pc_misalign;
`endif

    int total = 0;
    int bad   = 0;

    npc_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RST_VEC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_src      (pc_src),
`ifdef PC_MISALIGN_CHK_EN
        .pc_misalign (pc_misalign),
`endif
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset asserted at t0; the vector must appear without any clock edge.
        rst    = 1'b0;
        pc_src = 64'h1234;
        #1;
        check("reset_async", pc_out, RST_VEC);
`ifdef PC_MISALIGN_CHK_EN
        check("misalign_reset", {63'd0, pc_misalign}, 64'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_hold_%0d", i), pc_out, RST_VEC);
        end

        // Release between edges; first load on the next edge.
        #2;
        rst    = 1'b1;
        pc_src = 64'h8000_0004;
        #1;
        check("release_no_load", pc_out, RST_VEC);
        tick();
        check("first_load", pc_out, 64'h8000_0004);

        // Sequential +4 chain.
        for (logic [63:0] p = 64'h8000_0008; p <= 64'h8000_0010; p += 64'd4) begin
            pc_src = p;
            #1;
            check("seq_latency", pc_out, p - 64'd4);
            tick();
            check("seq_load", pc_out, p);
        end

        // Jump then fall-through.
        pc_src = 64'h8000_0100;
        tick();
        check("jump_target", pc_out, 64'h8000_0100);
        pc_src = 64'h8000_0104;
        #1;
        check("jump_hold", pc_out, 64'h8000_0100);
        tick();
        check("jump_next", pc_out, 64'h8000_0104);

        // Mid-cycle reset with pc_out at 0x8000_0100.
        pc_src = 64'h8000_0100;
        tick();
        check("pre_midreset", pc_out, 64'h8000_0100);
        #2;
        pc_src = 64'h8000_0200;
        rst    = 1'b0;
        #1;
        check("midreset_async", pc_out, RST_VEC);
        tick();
        check("midreset_discard", pc_out, RST_VEC);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_release", pc_out, RST_VEC);
        tick();
        check("after_midreset", pc_out, 64'h8000_0200);

        // Wrap-around: top of address space, then zero.
        pc_src = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        check("wrap_top", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        pc_src = 64'h0;
        tick();
        check("wrap_zero", pc_out, 64'h0);

        // Misaligned values are stored verbatim.
        pc_src = 64'h8000_0002;
        tick();
        check("misaligned_verbatim", pc_out, 64'h8000_0002);
`ifdef PC_MISALIGN_CHK_EN
        check("misalign_set", {63'd0, pc_misalign}, 64'd1);
`endif
        pc_src = 64'h8000_0004;
        tick();
        check("realigned", pc_out, 64'h8000_0004);
`ifdef PC_MISALIGN_CHK_EN
        check("misalign_clear", {63'd0, pc_misalign}, 64'd0);
`endif

        // All bits propagate.
        pc_src = 64'hA5A5_5A5A_C3C3_3C3D;
        tick();
        check("all_bits", pc_out, 64'hA5A5_5A5A_C3C3_3C3D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_npc_pc_reg
